// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_RESP} state_e;

  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    if (wr) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-data extension: sign/zero-extends assembled bytes according to funct3.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] assembled_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    rdata_o = assembled_i;
    case (func3_i)
      F3_B:    rdata_o = {{24{assembled_i[7]}}, assembled_i[7:0]};
      F3_H:    rdata_o = {{16{assembled_i[15]}}, assembled_i[15:0]};
      F3_BU:   rdata_o = {24'h0, assembled_i[7:0]};
      F3_HU:   rdata_o = {16'h0, assembled_i[15:0]};
      default: rdata_o = assembled_i;
    endcase
  end

endmodule

// File: rtl/lsu_byte_master.sv
// Serialises one RV32 load/store into little-endian byte cycles on a
// byte-wide synchronous memory port and returns a single response pulse.
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            state_q, state_d;
  logic              write_q, err_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, asm_q, ext_rdata;
  logic [1:0]        cnt_q, rd_idx_q;
  logic              rd_vld_q;
  logic              accept, last_byte;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign last_byte = ({1'b0, cnt_q} == (byte_count(func3_q) - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = f3_legal(req_write, req_func3) ? S_ACCESS : S_RESP;
      S_ACCESS: if (last_byte) state_d = write_q ? S_RESP : S_DRAIN;
      S_DRAIN:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Read data lags its strobe by one cycle, so the byte index is delayed too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      func3_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      asm_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        func3_q <= req_func3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= !f3_legal(req_write, req_func3);
        cnt_q   <= '0;
        asm_q   <= '0;
      end
      if (state_q == S_ACCESS) cnt_q <= cnt_q + 2'd1;
      rd_vld_q <= (state_q == S_ACCESS) && !write_q;
      rd_idx_q <= cnt_q;
      if (rd_vld_q) asm_q[{rd_idx_q, 3'b000} +: 8] <= mem_rdata;
    end
  end

  lsu_extend u_ext (
    .assembled_i (asm_q),
    .func3_i     (func3_q),
    .rdata_o     (ext_rdata)
  );

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_en     = (state_q == S_ACCESS);
    mem_we     = mem_en && write_q;
    mem_addr   = mem_en ? addr_q + ADDR_W'(cnt_q) : '0;
    mem_wdata  = mem_we ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    resp_valid = (state_q == S_RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !err_q && !write_q) ? ext_rdata : 32'h0;
  end

endmodule
